// File: rtl/cordic_pkg.sv
// Shared Q2.30 format constants and the arctangent table for the cosine CORDIC pipeline.
package cordic_pkg;

  localparam int unsigned Q_WIDTH = 32;
  localparam int unsigned Q_FRAC  = 30;

  typedef logic signed [Q_WIDTH-1:0] q_t;

  localparam q_t CORDIC_K  = 32'sh26DD3B6A;
  localparam q_t Q_SAT_POS = 32'sh7FFFFFFF;
  localparam q_t Q_SAT_NEG = 32'sh80000001;

  // Beyond i=10 atan(2^-i) rounds to exactly 2^-i in Q2.30.
  function automatic q_t atan_q30(input int unsigned i);
    case (i)
      0:       atan_q30 = 32'sh3243F6A9;
      1:       atan_q30 = 32'sh1DAC6705;
      2:       atan_q30 = 32'sh0FADBAFD;
      3:       atan_q30 = 32'sh07F56EA7;
      4:       atan_q30 = 32'sh03FEAB77;
      5:       atan_q30 = 32'sh01FFD55C;
      6:       atan_q30 = 32'sh00FFFAAB;
      7:       atan_q30 = 32'sh007FFF55;
      8:       atan_q30 = 32'sh003FFFEB;
      9:       atan_q30 = 32'sh001FFFFD;
      default: atan_q30 = (i <= 30) ? (q_t'(1) << (30 - i)) : '0;
    endcase
  endfunction

endpackage

// File: rtl/cordic_cos_pipe_stage.sv
// One registered CORDIC micro-rotation in rotation mode, rotating by atan(2^-SHIFT).
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int unsigned SHIFT = 0
) (
  input  logic clk,
  input  logic rst,
  input  q_t   x,
  input  q_t   y,
  input  q_t   z,
  output q_t   x_rot,
  output q_t   y_rot,
  output q_t   z_rot
);

  localparam q_t ATAN = atan_q30(SHIFT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_rot <= '0;
      y_rot <= '0;
      z_rot <= '0;
    end else if (!z[Q_WIDTH-1]) begin
      x_rot <= x - (y >>> SHIFT);
      y_rot <= y + (x >>> SHIFT);
      z_rot <= z - ATAN;
    end else begin
      x_rot <= x + (y >>> SHIFT);
      y_rot <= y - (x >>> SHIFT);
      z_rot <= z + ATAN;
    end
  end

endmodule

// File: rtl/cordic_cos_pipe.sv
// Fully pipelined float32 cos(theta): float->Q2.30, ITERATIONS CORDIC stages, Q2.30->float.
module cordic_cos_pipe
  import cordic_pkg::*;
#(
  parameter int unsigned ITERATIONS = 16,
  parameter int unsigned FRAC_BITS  = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] fixedpoint_in,
  output logic [31:0] fixedpoint_out,
  output logic [31:0] result
);

  // Exponent at which the 24-bit significand needs no shift to land in Q2.30.
  localparam logic [7:0] ALIGN_EXP = 8'(127 + 23 - FRAC_BITS);
  localparam logic [7:0] OUT_BIAS  = 8'(127 - FRAC_BITS);

  q_t          xs [0:ITERATIONS];
  q_t          ys [0:ITERATIONS];
  q_t          zs [0:ITERATIONS];
  logic [7:0]  exp_in;
  logic [31:0] mag_in;
  logic [31:0] fix_next;
  logic [31:0] mag_out;
  logic [31:0] norm;
  logic [4:0]  msb;
  logic [31:0] res_next;
  logic        unused_bits;

  always_comb begin
    exp_in   = dataa[30:23];
    mag_in   = {8'h00, 1'b1, dataa[22:0]};
    fix_next = '0;
    if (exp_in == 8'd0) begin
      fix_next = '0;
    end else if (exp_in >= 8'd128) begin
      fix_next = dataa[31] ? Q_SAT_NEG : Q_SAT_POS;
    end else begin
      if (exp_in >= ALIGN_EXP) mag_in = mag_in << (exp_in - ALIGN_EXP);
      else                     mag_in = mag_in >> (ALIGN_EXP - exp_in);
      fix_next = dataa[31] ? (-mag_in) : mag_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fixedpoint_in <= '0;
    else      fixedpoint_in <= fix_next;
  end

  assign xs[0] = CORDIC_K;
  assign ys[0] = '0;
  assign zs[0] = q_t'(fixedpoint_in);

  for (genvar i = 0; i < ITERATIONS; i++) begin : g_stage
    cordic_stage #(.SHIFT(i)) u_stage (
      .clk   (clk),
      .rst   (rst),
      .x     (xs[i]),
      .y     (ys[i]),
      .z     (zs[i]),
      .x_rot (xs[i+1]),
      .y_rot (ys[i+1]),
      .z_rot (zs[i+1])
    );
  end

  assign fixedpoint_out = xs[ITERATIONS];

  always_comb begin
    mag_out = xs[ITERATIONS][31] ? 32'(-xs[ITERATIONS]) : xs[ITERATIONS];
    msb     = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (mag_out[i]) msb = 5'(i);
    end
    // Normalise so the leading one sits at bit 31; the next 23 bits are the mantissa.
    norm     = mag_out << (5'd31 - msb);
    res_next = '0;
    if (mag_out != '0) begin
      res_next = {xs[ITERATIONS][31], OUT_BIAS + {3'b000, msb}, norm[30:8]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) result <= '0;
    else      result <= res_next;
  end

  assign unused_bits = ^{datab, norm[31], norm[7:0]};

endmodule

// File: tb/tb_cordic_cos_pipe.sv
// Self-checking bench for cordic_cos_pipe: directed angles plus random angles against a real-arithmetic cosine model.
module tb_cordic_cos_pipe;

  localparam real Q   = 1073741824.0;
  localparam real TOL = 1.0 / 16384.0;

  localparam logic [31:0] PI6  = 32'h3F060A92;
  localparam logic [31:0] PI4  = 32'h3F490FDB;
  localparam logic [31:0] PI12 = 32'h3E860A92;
  localparam logic [31:0] NPI6 = 32'hBF060A92;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] dataa = '0;
  logic [31:0] datab = '0;
  logic [31:0] fixedpoint_in;
  logic [31:0] fixedpoint_out;
  logic [31:0] result;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned k        = 0;
  logic [31:0] a_hist [0:4095];

  always #5 clk = ~clk;

  cordic_cos_pipe #(.ITERATIONS(16), .FRAC_BITS(30)) dut (
    .clk            (clk),
    .rst            (rst),
    .dataa          (dataa),
    .datab          (datab),
    .fixedpoint_in  (fixedpoint_in),
    .fixedpoint_out (fixedpoint_out),
    .result         (result)
  );

  function automatic real f2r(input logic [31:0] b);
    int  e;
    real m;
    e = int'(b[30:23]);
    if (e == 0) return 0.0;
    m = (1.0 + real'(b[22:0]) / 8388608.0) * $pow(2.0, real'(e - 127));
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] fix_model(input logic [31:0] a);
    if (a[30:23] == 8'd0)   return '0;
    if (a[30:23] >= 8'd128) return a[31] ? 32'h80000001 : 32'h7FFFFFFF;
    return 32'($rtoi(f2r(a) * Q));
  endfunction

  function automatic real q2r(input logic [31:0] v);
    return $itor($signed(v)) / Q;
  endfunction

  function automatic logic [31:0] rand_angle();
    logic [31:0] m;
    logic [7:0]  e;
    m = $urandom;
    e = 8'($urandom_range(100, 126));
    return {m[31], e, m[22:0]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input logic [31:0] obs_bits, input real obs, input real exp);
    logic ok;
    ok = ((obs - exp) <= TOL) && ((exp - obs) <= TOL);
    n_checks++;
    assert (ok === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: observed %h (%f) expected %f", tag, obs_bits, obs, exp);
    end
  endtask

  task automatic check_outputs();
    real t;
    check_eq("fixedpoint_in", fixedpoint_in, fix_model(a_hist[k]));
    if (k >= 17) begin
      t = f2r(a_hist[k-16]);
      if (t <= 1.0 && t >= -1.0) check_near("fixedpoint_out", fixedpoint_out, q2r(fixedpoint_out), $cos(t));
    end
    if (k >= 18) begin
      t = f2r(a_hist[k-17]);
      if (t <= 1.0 && t >= -1.0) check_near("result", result, f2r(result), $cos(t));
    end
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] b);
    dataa = a;
    datab = b;
    @(posedge clk);
    #1;
    k++;
    a_hist[k] = a;
    check_outputs();
  endtask

  task automatic hold_reset(input int n);
    rst = 1'b0;
    for (int i = 0; i < n; i++) begin
      dataa = $urandom;
      datab = $urandom;
      @(posedge clk);
      #1;
      check_eq("reset fixedpoint_in", fixedpoint_in, 32'h0);
      check_eq("reset fixedpoint_out", fixedpoint_out, 32'h0);
      check_eq("reset result", result, 32'h0);
    end
    k = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    hold_reset(4);
    rst = 1'b1;

    // Held operand: result must appear exactly on the 18th edge, not before.
    for (int i = 1; i <= 18; i++) begin
      step(PI6, 32'd0);
      if (i == 1) check_eq("pi6 fixedpoint_in", fixedpoint_in, 32'h2182A480);
      if (i == 17) begin
        n_checks++;
        assert ((f2r(result) - $cos(f2r(PI6)) > TOL) || ($cos(f2r(PI6)) - f2r(result) > TOL)) else begin
          n_fail++;
          $error("FAIL latency_early: observed %h already matches cos(pi/6) at edge 17", result);
        end
      end
    end
    check_near("pi6 result", result, f2r(result), f2r(32'h3F5DB3D7));
    check_near("pi6 fixedpoint_out", fixedpoint_out, q2r(fixedpoint_out), q2r(32'h376CF5D1));

    // Back-to-back operands with unrelated datab values.
    step(PI6, 32'd2);
    step(PI4, 32'd22);
    check_eq("pi4 fixedpoint_in", fixedpoint_in, 32'h3243F6C0);
    step(PI12, 32'd23);
    check_eq("pi12 fixedpoint_in", fixedpoint_in, 32'h10C15240);

    // Edge operands.
    step(32'h00000000, $urandom);
    check_eq("zero fixedpoint_in", fixedpoint_in, 32'h0);
    step(NPI6, $urandom);
    check_eq("neg pi6 fixedpoint_in", fixedpoint_in, 32'hDE7D5B80);
    step(32'h40800000, $urandom);
    check_eq("sat pos fixedpoint_in", fixedpoint_in, 32'h7FFFFFFF);
    step(32'hC0800000, $urandom);
    check_eq("sat neg fixedpoint_in", fixedpoint_in, 32'h80000001);
    step(32'h00400000, $urandom);
    check_eq("denormal fixedpoint_in", fixedpoint_in, 32'h0);

    for (int i = 0; i < 60; i++) step(rand_angle(), $urandom);
    check_near("cos zero result", result, f2r(result), $cos(f2r(a_hist[k-17])));

    // Asynchronous reset mid-stream flushes everything immediately.
    rst = 1'b0;
    #1;
    check_eq("async fixedpoint_in", fixedpoint_in, 32'h0);
    check_eq("async fixedpoint_out", fixedpoint_out, 32'h0);
    check_eq("async result", result, 32'h0);
    hold_reset(2);
    rst = 1'b1;

    for (int i = 0; i < 40; i++) step(rand_angle(), $urandom);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
